// File: rtl/systolic_pkg.sv
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared FSM state encoding and sizing/slicing helpers for the
//             weight-stationary systolic array sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  // Sequencer states, explicitly 3 bits wide.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // LSB position of a lane inside a packed row of DATA_WIDTH-bit elements.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

  // Counter width able to hold max_count without wrapping.
  function automatic int unsigned ctr_width(input int unsigned max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_skew.sv
// ============================================================================
//  Module   : systolic_skew
//  Purpose  : Input skew stage for the systolic array. Lane i of the vector
//             is delayed by i cycles so that the diagonal wavefront lines up
//             with the array's PE pipeline. Lane 0 passes straight through.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_skew
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] i_vec,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] o_vec
);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    if (i == 0) begin : g_pass
      assign o_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = i_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] r_sr [i];

      // Lane shift register of depth i, cleared on reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int j = 0; j < i; j++) r_sr[j] <= '0;
        end else begin
          r_sr[0] <= i_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
          for (int j = 1; j < i; j++) r_sr[j] <= r_sr[j-1];
        end
      end

      assign o_vec[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = r_sr[i-1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/systolic_ctrl.sv
// ============================================================================
//  Module   : systolic_ctrl
//  Purpose  : Sequencer for an ARRAY_SIZE x ARRAY_SIZE weight-stationary
//             systolic array. Accepts ARRAY_SIZE weight rows, then num_vecs
//             activation vectors, drives the array and flags output rows.
//  Config   : SYSTOLIC_SKEW_EN - when defined, activations are skewed
//             internally (lane i delayed i cycles); otherwise upstream
//             supplies pre-skewed data and DRAIN is ARRAY_SIZE-1 shorter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int DATA_WIDTH = 4,
  parameter int OUT_LAT    = 2*ARRAY_SIZE-1,
  parameter int VEC_W      = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [VEC_W-1:0]                 num_vecs,
  input  logic                             w_valid,
  output logic                             w_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
  input  logic                             a_valid,
  output logic                             a_ready,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
  output logic                             arr_load,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_weights,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] arr_activations,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int c_row_w = ARRAY_SIZE * DATA_WIDTH;
`ifdef SYSTOLIC_SKEW_EN
  localparam int c_skew_extra = ARRAY_SIZE - 1;
`else
  localparam int c_skew_extra = 0;
`endif
  // DRAIN covers the register stage plus the full valid delay line, plus the
  // time the skew stage needs to flush its deepest lane.
  localparam int c_drain_len = OUT_LAT + 1 + c_skew_extra;
  localparam int c_wcnt_w    = ctr_width(ARRAY_SIZE);
  localparam int c_dcnt_w    = ctr_width(OUT_LAT + ARRAY_SIZE);

  state_t                r_state, w_state_next;
  logic [c_wcnt_w-1:0]   r_wcnt;
  logic [VEC_W-1:0]      r_vcnt;
  logic [VEC_W-1:0]      r_num_vecs;
  logic [c_dcnt_w-1:0]   r_dcnt;
  logic [OUT_LAT:0]      r_vld_pipe;
  logic                  w_row_beat, w_vec_beat;
  logic                  w_last_row, w_last_vec, w_drain_end;
  logic [c_row_w-1:0]    w_act_in, w_act_skewed;

  assign w_row_beat  = w_valid && w_ready;
  assign w_vec_beat  = a_valid && a_ready;
  assign w_last_row  = w_row_beat && (r_wcnt == c_wcnt_w'(ARRAY_SIZE - 1));
  assign w_last_vec  = w_vec_beat && (r_vcnt == (r_num_vecs - VEC_W'(1)));
  assign w_drain_end = (r_dcnt == c_dcnt_w'(c_drain_len - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake/status decode. busy is low in DONE so that it
  // falls in the same cycle done pulses.
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    a_ready      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE:   if (start) w_state_next = LOAD;
      LOAD: begin
        w_ready = 1'b1;
        busy    = 1'b1;
        if (w_last_row) w_state_next = STREAM;
      end
      STREAM: begin
        a_ready = 1'b1;
        busy    = 1'b1;
        if (w_last_vec) w_state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_drain_end) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Job counters; num_vecs of zero is latched as one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt     <= '0;
      r_vcnt     <= '0;
      r_dcnt     <= '0;
      r_num_vecs <= '0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_num_vecs <= (num_vecs == '0) ? VEC_W'(1) : num_vecs;
        r_wcnt     <= '0;
        r_vcnt     <= '0;
        r_dcnt     <= '0;
      end
    end else begin
      if (w_row_beat)         r_wcnt <= r_wcnt + c_wcnt_w'(1);
      if (w_vec_beat)         r_vcnt <= r_vcnt + VEC_W'(1);
      if (r_state == DRAIN)   r_dcnt <= r_dcnt + c_dcnt_w'(1);
    end
  end

  // Bubble cycles inject an all-zero vector.
  assign w_act_in = w_vec_beat ? a_data : '0;

`ifdef SYSTOLIC_SKEW_EN
  systolic_skew #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew (
    .clk   (clk),
    .reset (reset),
    .i_vec (w_act_in),
    .o_vec (w_act_skewed)
  );
`else
  assign w_act_skewed = w_act_in;
`endif

  // Registered array-side outputs and the output-row valid delay line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arr_load        <= 1'b0;
      arr_weights     <= '0;
      arr_activations <= '0;
      r_vld_pipe      <= '0;
    end else begin
      arr_load        <= w_row_beat;
      arr_weights     <= w_row_beat ? w_data : '0;
      arr_activations <= w_act_skewed;
      r_vld_pipe      <= {r_vld_pipe[OUT_LAT-1:0], w_vec_beat};
    end
  end

  // Stage 0 aligns with arr_activations; the tap sits OUT_LAT cycles later.
  assign out_valid = r_vld_pipe[OUT_LAT];

endmodule

`default_nettype wire

// File: tb/tb_systolic_ctrl.sv
`default_nettype none

module tb_systolic_ctrl;

  localparam int N       = 8;
  localparam int DW      = 4;
  localparam int VW      = 8;
  localparam int OUT_LAT = 2*N - 1;
  localparam int BW      = N * DW;
`ifdef SYSTOLIC_SKEW_EN
  localparam bit SKEW       = 1'b1;
  localparam int SKEW_EXTRA = N - 1;
`else
  localparam bit SKEW       = 1'b0;
  localparam int SKEW_EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [VW-1:0] num_vecs = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [BW-1:0] w_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready;
  logic [BW-1:0] a_data = '0;
  logic          arr_load;
  logic [BW-1:0] arr_weights;
  logic [BW-1:0] arr_activations;
  logic          out_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  systolic_ctrl #(
    .ARRAY_SIZE (N),
    .DATA_WIDTH (DW),
    .OUT_LAT    (OUT_LAT),
    .VEC_W      (VW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_vecs        (num_vecs),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .a_valid         (a_valid),
    .a_ready         (a_ready),
    .a_data          (a_data),
    .arr_load        (arr_load),
    .arr_weights     (arr_weights),
    .arr_activations (arr_activations),
    .out_valid       (out_valid),
    .busy            (busy),
    .done            (done)
  );

  int tests   = 0;
  int fails   = 0;
  int cyc     = 0;
  int done_at = 0;
  int ov_seen = 0;

  // Expected array-side outputs, indexed by cycle number modulo 256.
  logic          exp_load [256];
  logic [BW-1:0] exp_w    [256];
  logic [BW-1:0] exp_act  [256];
  logic          exp_ov   [256];
  logic          exp_done [256];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chkv(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) begin
      exp_load[i] = 1'b0;
      exp_w[i]    = '0;
      exp_act[i]  = '0;
      exp_ov[i]   = 1'b0;
      exp_done[i] = 1'b0;
    end
  endtask

  task automatic check_cycle();
    int i;
    i = cyc % 256;
    chk1("arr_load",        arr_load,        exp_load[i]);
    chkv("arr_weights",     arr_weights,     exp_w[i]);
    chkv("arr_activations", arr_activations, exp_act[i]);
    chk1("out_valid",       out_valid,       exp_ov[i]);
    chk1("done",            done,            exp_done[i]);
    if (out_valid === 1'b1) ov_seen++;
    exp_load[i] = 1'b0;
    exp_w[i]    = '0;
    exp_act[i]  = '0;
    exp_ov[i]   = 1'b0;
    exp_done[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic do_start(input int nv);
    tick();
    chk1("busy_idle", busy, 1'b0);
    chk1("w_ready_idle", w_ready, 1'b0);
    num_vecs = VW'(nv);
    start    = 1'b1;
    tick();
    start   = 1'b0;
    ov_seen = 0;
    chk1("busy_load", busy, 1'b1);
  endtask

  task automatic load_rows(input bit gap, input logic [BW-1:0] base);
    for (int k = 0; k < N; k++) begin
      if (gap) begin
        w_valid = 1'b0;
        w_data  = '1;
        chk1("w_ready_bubble", w_ready, 1'b1);
        tick();
      end
      w_valid = 1'b1;
      w_data  = gap ? (base ^ BW'(k)) : base;
      chk1("w_ready_load", w_ready, 1'b1);
      chk1("a_ready_load", a_ready, 1'b0);
      exp_load[(cyc+1) % 256] = 1'b1;
      exp_w[(cyc+1) % 256]    = w_data;
      tick();
    end
    w_valid = 1'b0;
    w_data  = '0;
    chk1("w_ready_stream", w_ready, 1'b0);
    chk1("a_ready_stream", a_ready, 1'b1);
  endtask

  // mode 0: lane 0 carries v+1, other lanes zero; mode 1: all lanes busy.
  task automatic stream_vecs(input int nv, input bit gap, input bit mode, input int limit);
    int nv_eff;
    nv_eff = (nv == 0) ? 1 : nv;
    for (int v = 0; v < nv_eff && v < limit; v++) begin
      if (gap) begin
        a_valid = 1'b0;
        a_data  = '1;
        chk1("a_ready_bubble", a_ready, 1'b1);
        tick();
      end
      a_valid = 1'b1;
      a_data  = mode ? (BW'(32'h1357_9BDF) ^ BW'(v * 32'h1111_1111)) : BW'(v + 1);
      chk1("a_ready_beat", a_ready, 1'b1);
      for (int k = 0; k < N; k++)
        exp_act[(cyc + 1 + (SKEW ? k : 0)) % 256][k*DW +: DW] = a_data[k*DW +: DW];
      exp_ov[(cyc + 1 + OUT_LAT) % 256] = 1'b1;
      tick();
    end
    a_valid = 1'b0;
    a_data  = '0;
    if (limit >= nv_eff) begin
      chk1("a_ready_drain", a_ready, 1'b0);
      chk1("busy_drain_entry", busy, 1'b1);
      done_at = cyc + OUT_LAT + 1 + SKEW_EXTRA;
      exp_done[done_at % 256] = 1'b1;
    end
  endtask

  task automatic drain_wait(input int nv_eff);
    while (cyc < done_at) begin
      tick();
      if (cyc < done_at) chk1("busy_drain", busy, 1'b1);
    end
    chk1("busy_done", busy, 1'b0);
    chk1("a_ready_done", a_ready, 1'b0);
    chkv("out_valid_count", BW'(ov_seen), BW'(nv_eff));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    clear_exp();

    // Reset state.
    tick();
    tick();
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_w_ready", w_ready, 1'b0);
    chk1("reset_a_ready", a_ready, 1'b0);
    reset = 1'b1;

    // Reset mid-STREAM aborts the job without a done pulse.
    do_start(8);
    load_rows(1'b0, 32'h8765_4321);
    stream_vecs(8, 1'b0, 1'b1, 3);
    reset = 1'b0;
    #1;
    chk1("abort_arr_load", arr_load, 1'b0);
    chkv("abort_arr_weights", arr_weights, '0);
    chkv("abort_arr_act", arr_activations, '0);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_a_ready", a_ready, 1'b0);
    clear_exp();
    tick();
    tick();
    reset = 1'b1;

    // Back-to-back weight rows, then lane-0 ramp 1..8.
    do_start(8);
    load_rows(1'b0, 32'h8765_4321);
    stream_vecs(8, 1'b0, 1'b0, 8);
    drain_wait(8);

    // Valid toggling 1-0-1 on both streams.
    do_start(8);
    load_rows(1'b1, 32'hA5C3_0F96);
    stream_vecs(8, 1'b1, 1'b1, 8);
    drain_wait(8);

    // num_vecs = 0 behaves as 1; start held high through DONE.
    do_start(0);
    start    = 1'b1;
    num_vecs = VW'(2);
    load_rows(1'b0, 32'h0F1E_2D3C);
    stream_vecs(0, 1'b0, 1'b1, 8);
    drain_wait(1);
    tick();
    chk1("held_start_idle_busy", busy, 1'b0);
    chk1("held_start_idle_w_ready", w_ready, 1'b0);
    tick();
    chk1("held_start_load_busy", busy, 1'b1);
    chk1("held_start_load_w_ready", w_ready, 1'b1);
    start   = 1'b0;
    ov_seen = 0;
    load_rows(1'b0, 32'h1234_5678);
    stream_vecs(2, 1'b0, 1'b0, 8);
    drain_wait(2);

    tick();
    chk1("final_busy", busy, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
